// File: rtl/enemy_hit_ctrl_if.sv
// Spawner/bullet-side bus of the enemy hit controller.
// The master drives spawn, hit, enable and vsync; the slave returns the kill, explosion, score and flash state.
interface enemy_hit_ctrl_if #(
    parameter int unsigned MAX_ENEMY_NUM         = 10,
    parameter int unsigned MAX_ENEMY_NUM_BIT_LEN = 4,
    parameter int unsigned EXPLODE_BIT_LEN       = 3,
    parameter int unsigned SCORE_BIT_LEN         = 16
);
    logic                                       en_i;
    logic                                       v_sync_i;
    logic                                       trigger_i;
    logic [MAX_ENEMY_NUM_BIT_LEN-1:0]           trigger_idx_i;
    logic                                       hit_i;
    logic [MAX_ENEMY_NUM_BIT_LEN-1:0]           hit_idx_i;
    logic [MAX_ENEMY_NUM-1:0]                   disappear_o;
    logic [MAX_ENEMY_NUM-1:0]                   exploding_o;
    logic [MAX_ENEMY_NUM*EXPLODE_BIT_LEN-1:0]   explode_step_o;
    logic                                       kill_o;
    logic [SCORE_BIT_LEN-1:0]                   score_o;
    logic [MAX_ENEMY_NUM-1:0]                   flash_o;

    modport master (
        output en_i, v_sync_i, trigger_i, trigger_idx_i, hit_i, hit_idx_i,
        input  disappear_o, exploding_o, explode_step_o, kill_o, score_o, flash_o
    );

    modport slave (
        input  en_i, v_sync_i, trigger_i, trigger_idx_i, hit_i, hit_idx_i,
        output disappear_o, exploding_o, explode_step_o, kill_o, score_o, flash_o
    );
endinterface

// File: rtl/enemy_hit_ctrl.sv
// Per-slot enemy HP, kill pulse, explosion sequencing and kill score for one enemy class.
// Optional hit flash is enabled by defining ENEMY_HIT_FLASH_EN.
module enemy_hit_ctrl #(
    parameter int unsigned MAX_ENEMY_NUM         = 10,
    parameter int unsigned MAX_ENEMY_NUM_BIT_LEN = 4,
    parameter int unsigned ENEMY_HP              = 3,
    parameter int unsigned HP_BIT_LEN            = 2,
    parameter int unsigned EXPLODE_FRAMES        = 8,
    parameter int unsigned EXPLODE_BIT_LEN       = 3,
    parameter int unsigned SCORE_PER_KILL        = 1,
    parameter int unsigned SCORE_BIT_LEN         = 16
) (
    input  logic             clk_run,
    input  logic             rst,
    enemy_hit_ctrl_if.slave  bus
);
    localparam int unsigned STEP_LAST = EXPLODE_FRAMES - 1;
    localparam int unsigned SUM_W     = SCORE_BIT_LEN + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ALIVE   = 2'd1,
        S_EXPLODE = 2'd2
    } slot_state_e;

    slot_state_e                state_q [MAX_ENEMY_NUM];
    slot_state_e                state_d [MAX_ENEMY_NUM];
    logic [HP_BIT_LEN-1:0]      hp_q    [MAX_ENEMY_NUM];
    logic [HP_BIT_LEN-1:0]      hp_d    [MAX_ENEMY_NUM];
    logic [EXPLODE_BIT_LEN-1:0] step_q  [MAX_ENEMY_NUM];
    logic [EXPLODE_BIT_LEN-1:0] step_d  [MAX_ENEMY_NUM];
    logic [MAX_ENEMY_NUM-1:0]   disappear_q, disappear_d;
    logic                       kill_q, kill_d;
    logic [SCORE_BIT_LEN-1:0]   score_q, score_d;
    logic [SUM_W-1:0]           score_sum;
    logic [2:0]                 vs_q, vs_d;
    logic                       tick;
    logic [MAX_ENEMY_NUM-1:0]   kill_vec;
    logic                       trig_hit, hit_hit;
`ifdef ENEMY_HIT_FLASH_EN
    logic [MAX_ENEMY_NUM-1:0]   flash_q, flash_d;
`endif

    // vsync is idle-high; sync stages reset high so reset release never looks like a frame edge
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) vs_q <= 3'b111;
        else     vs_q <= vs_d;
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                state_q[i] <= S_IDLE;
                hp_q[i]    <= '0;
                step_q[i]  <= '0;
            end
            disappear_q <= '0;
            kill_q      <= 1'b0;
            score_q     <= '0;
`ifdef ENEMY_HIT_FLASH_EN
            flash_q     <= '0;
`endif
        end else begin
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                state_q[i] <= state_d[i];
                hp_q[i]    <= hp_d[i];
                step_q[i]  <= step_d[i];
            end
            disappear_q <= disappear_d;
            kill_q      <= kill_d;
            score_q     <= score_d;
`ifdef ENEMY_HIT_FLASH_EN
            flash_q     <= flash_d;
`endif
        end
    end

    always_comb begin
        vs_d        = {vs_q[1:0], bus.v_sync_i};
        tick        = vs_q[2] & ~vs_q[1];
        kill_vec    = '0;
        trig_hit    = 1'b0;
        hit_hit     = 1'b0;
        disappear_d = '0;
        kill_d      = 1'b0;
        score_d     = score_q;
        score_sum   = {1'b0, score_q} + SUM_W'(SCORE_PER_KILL);
        for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
            state_d[i] = state_q[i];
            hp_d[i]    = hp_q[i];
            step_d[i]  = step_q[i];
        end
`ifdef ENEMY_HIT_FLASH_EN
        flash_d = flash_q;
        if (bus.en_i && tick) flash_d = '0;
`endif
        if (bus.en_i) begin
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                trig_hit = bus.trigger_i && (bus.trigger_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i));
                hit_hit  = bus.hit_i && (bus.hit_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i));
                // A spawn always wins, including over a same-cycle hit or a running explosion
                if (trig_hit) begin
                    state_d[i] = S_ALIVE;
                    hp_d[i]    = HP_BIT_LEN'(ENEMY_HP);
                    step_d[i]  = '0;
`ifdef ENEMY_HIT_FLASH_EN
                    flash_d[i] = 1'b0;
`endif
                end else begin
                    unique case (state_q[i])
                        S_ALIVE: begin
                            if (hit_hit) begin
                                if (hp_q[i] > HP_BIT_LEN'(1)) begin
                                    hp_d[i] = hp_q[i] - HP_BIT_LEN'(1);
`ifdef ENEMY_HIT_FLASH_EN
                                    flash_d[i] = 1'b1;
`endif
                                end else begin
                                    state_d[i]  = S_EXPLODE;
                                    hp_d[i]     = '0;
                                    step_d[i]   = '0;
                                    kill_vec[i] = 1'b1;
`ifdef ENEMY_HIT_FLASH_EN
                                    flash_d[i]  = 1'b0;
`endif
                                end
                            end
                        end
                        S_EXPLODE: begin
                            if (tick) begin
                                if (step_q[i] == EXPLODE_BIT_LEN'(STEP_LAST)) begin
                                    state_d[i] = S_IDLE;
                                    step_d[i]  = '0;
                                end else begin
                                    step_d[i] = step_q[i] + EXPLODE_BIT_LEN'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            disappear_d = kill_vec;
            kill_d      = |kill_vec;
            // Saturate rather than wrap
            if (kill_d) score_d = score_sum[SCORE_BIT_LEN] ? '1 : score_sum[SCORE_BIT_LEN-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
            bus.exploding_o[i] = (state_q[i] == S_EXPLODE);
            bus.explode_step_o[i*EXPLODE_BIT_LEN +: EXPLODE_BIT_LEN] = step_q[i];
        end
    end

    assign bus.disappear_o = disappear_q;
    assign bus.kill_o      = kill_q;
    assign bus.score_o     = score_q;
`ifdef ENEMY_HIT_FLASH_EN
    assign bus.flash_o     = flash_q;
`else
    assign bus.flash_o     = '0;
`endif
endmodule

// File: tb/tb_enemy_hit_ctrl.sv
// Scoreboard bench for enemy_hit_ctrl: expected kills are queued with the lethal hit and matched on each kill pulse.
// A second instance with a 2-bit score checks saturation.
module tb_enemy_hit_ctrl;
    localparam int unsigned N  = 10;
    localparam int unsigned IW = 4;
    localparam int unsigned EW = 3;
    localparam int unsigned SW = 16;

    typedef struct packed {
        logic [N-1:0]  dis;
        logic [SW-1:0] score;
    } exp_t;

    logic clk_run = 1'b0;
    logic rst;
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_run = ~clk_run;

    enemy_hit_ctrl_if #(.MAX_ENEMY_NUM(N), .MAX_ENEMY_NUM_BIT_LEN(IW),
                        .EXPLODE_BIT_LEN(EW), .SCORE_BIT_LEN(SW)) bus ();
    enemy_hit_ctrl_if #(.MAX_ENEMY_NUM(N), .MAX_ENEMY_NUM_BIT_LEN(IW),
                        .EXPLODE_BIT_LEN(EW), .SCORE_BIT_LEN(2)) bus_sat ();

    assign bus_sat.en_i          = bus.en_i;
    assign bus_sat.v_sync_i      = bus.v_sync_i;
    assign bus_sat.trigger_i     = bus.trigger_i;
    assign bus_sat.trigger_idx_i = bus.trigger_idx_i;
    assign bus_sat.hit_i         = bus.hit_i;
    assign bus_sat.hit_idx_i     = bus.hit_idx_i;

    enemy_hit_ctrl #(
        .MAX_ENEMY_NUM(N), .MAX_ENEMY_NUM_BIT_LEN(IW), .ENEMY_HP(3), .HP_BIT_LEN(2),
        .EXPLODE_FRAMES(8), .EXPLODE_BIT_LEN(EW), .SCORE_PER_KILL(1), .SCORE_BIT_LEN(SW)
    ) u_dut (
        .clk_run (clk_run),
        .rst     (rst),
        .bus     (bus)
    );

    enemy_hit_ctrl #(
        .MAX_ENEMY_NUM(N), .MAX_ENEMY_NUM_BIT_LEN(IW), .ENEMY_HP(3), .HP_BIT_LEN(2),
        .EXPLODE_FRAMES(8), .EXPLODE_BIT_LEN(EW), .SCORE_PER_KILL(1), .SCORE_BIT_LEN(2)
    ) u_dut_sat (
        .clk_run (clk_run),
        .rst     (rst),
        .bus     (bus_sat)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Every kill pulse must match the next queued expectation; a held pulse pops an empty queue
    always @(negedge clk_run) begin
        if (!rst && (bus.disappear_o != '0 || bus.kill_o)) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_kill", {21'b0, bus.kill_o, bus.disappear_o}, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("disappear", 32'(bus.disappear_o), 32'(mon_e.dis));
                check_eq("kill_o", 32'(bus.kill_o), 32'h1);
                check_eq("score", 32'(bus.score_o), 32'(mon_e.score));
            end
        end
    end

    function automatic logic [31:0] step_of(input int idx);
        return 32'(bus.explode_step_o[idx*EW +: EW]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_run);
    endtask

    task automatic do_trig(input int idx);
        bus.trigger_i     = 1'b1;
        bus.trigger_idx_i = IW'(idx);
        @(negedge clk_run);
        bus.trigger_i     = 1'b0;
    endtask

    task automatic do_hit(input int idx);
        bus.hit_i     = 1'b1;
        bus.hit_idx_i = IW'(idx);
        @(negedge clk_run);
        bus.hit_i     = 1'b0;
    endtask

    task automatic vs_tick();
        bus.v_sync_i = 1'b0;
        cyc(3);
        bus.v_sync_i = 1'b1;
        cyc(3);
    endtask

    task automatic drain(input string tag);
        cyc(2);
        check_eq(tag, 32'(sb_q.size()), 32'h0);
    endtask

    task automatic kill_slot(input int idx, input int exp_score);
        exp_t e;
        do_trig(idx);
        cyc(2);
        do_hit(idx);
        cyc(2);
        do_hit(idx);
        cyc(2);
        e.dis   = N'(1) << idx;
        e.score = SW'(exp_score);
        sb_q.push_back(e);
        do_hit(idx);
        drain("kill_drain");
    endtask

    initial begin
        exp_t e;
        rst               = 1'b1;
        bus.en_i          = 1'b1;
        bus.v_sync_i      = 1'b1;
        bus.trigger_i     = 1'b0;
        bus.trigger_idx_i = '0;
        bus.hit_i         = 1'b0;
        bus.hit_idx_i     = '0;
        cyc(2);
        check_eq("rst_disappear", 32'(bus.disappear_o), 32'h0);
        check_eq("rst_exploding", 32'(bus.exploding_o), 32'h0);
        check_eq("rst_step", 32'(bus.explode_step_o), 32'h0);
        check_eq("rst_kill", 32'(bus.kill_o), 32'h0);
        check_eq("rst_score", 32'(bus.score_o), 32'h0);
        check_eq("rst_flash", 32'(bus.flash_o), 32'h0);
        rst = 1'b0;
        cyc(2);

        // Basic kill on slot 2
        do_trig(2);
        cyc(5);
        do_hit(2);
        cyc(4);
        do_hit(2);
        cyc(4);
        e.dis = 10'h004; e.score = 16'd1;
        sb_q.push_back(e);
        do_hit(2);
        drain("t1_drain");
        check_eq("t1_disappear_gone", 32'(bus.disappear_o), 32'h0);
        check_eq("t1_exploding", 32'(bus.exploding_o), 32'h004);
        check_eq("t1_step0", step_of(2), 32'h0);
        check_eq("t1_score", 32'(bus.score_o), 32'd1);

        // Explosion counts one step per frame and ends after the 8th frame
        for (int k = 0; k < 8; k++) begin
            vs_tick();
            if (k < 7) begin
                check_eq("t2_step", step_of(2), 32'(k + 1));
                check_eq("t2_exploding", 32'(bus.exploding_o[2]), 32'h1);
            end
        end
        check_eq("t2_exploding_end", 32'(bus.exploding_o), 32'h0);
        check_eq("t2_step_end", step_of(2), 32'h0);

        // Same-cycle spawn and hit: the hit is discarded
        bus.trigger_i = 1'b1; bus.trigger_idx_i = IW'(4);
        bus.hit_i     = 1'b1; bus.hit_idx_i     = IW'(4);
        @(negedge clk_run);
        bus.trigger_i = 1'b0; bus.hit_i = 1'b0;
        cyc(2);
        do_hit(4);
        cyc(2);
        do_hit(4);
        cyc(2);
        check_eq("t3_alive", 32'(bus.exploding_o), 32'h0);
        e.dis = 10'h010; e.score = 16'd2;
        sb_q.push_back(e);
        do_hit(4);
        drain("t3_drain");

        // Freeze with en_i low
        do_trig(1);
        cyc(2);
        do_hit(1);
        cyc(2);
        vs_tick();
        check_eq("t4_step_pre", step_of(4), 32'h1);
        bus.en_i = 1'b0;
        do_hit(1);
        cyc(2);
        do_hit(1);
        vs_tick();
        vs_tick();
        check_eq("t4_step_frozen", step_of(4), 32'h1);
        check_eq("t4_exploding_frozen", 32'(bus.exploding_o), 32'h010);
        check_eq("t4_score_frozen", 32'(bus.score_o), 32'd2);
        bus.en_i = 1'b1;
        cyc(2);
        do_hit(1);
        cyc(2);
        e.dis = 10'h002; e.score = 16'd3;
        sb_q.push_back(e);
        do_hit(1);
        drain("t4_drain");
        check_eq("t4_sat_score", 32'(bus_sat.score_o), 32'd3);

        // Hits on an idle slot and an out-of-range index change nothing
        do_hit(7);
        cyc(2);
        do_hit(12);
        cyc(2);
        check_eq("t5_exploding", 32'(bus.exploding_o), 32'h012);
        check_eq("t5_score", 32'(bus.score_o), 32'd3);
        kill_slot(5, 4);
        kill_slot(6, 5);
        check_eq("t5_score_main", 32'(bus.score_o), 32'd5);
        check_eq("t5_sat_score", 32'(bus_sat.score_o), 32'd3);

        // Flash on non-lethal hit, then reset mid-explosion
        do_trig(0);
        cyc(2);
        do_hit(0);
`ifdef ENEMY_HIT_FLASH_EN
        check_eq("t6_flash_set", 32'(bus.flash_o), 32'h001);
        cyc(3);
        check_eq("t6_flash_hold", 32'(bus.flash_o), 32'h001);
        vs_tick();
        check_eq("t6_flash_clr", 32'(bus.flash_o), 32'h0);
`else
        check_eq("t6_flash_off", 32'(bus.flash_o), 32'h0);
        cyc(3);
        check_eq("t6_flash_off2", 32'(bus.flash_o), 32'h0);
`endif
        cyc(2);
        do_hit(0);
        cyc(2);
        e.dis = 10'h001; e.score = 16'd6;
        sb_q.push_back(e);
        do_hit(0);
        drain("t6_drain");
        check_eq("t6_flash_kill", 32'(bus.flash_o), 32'h0);
        check_eq("t6_exploding", 32'(bus.exploding_o[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_exploding", 32'(bus.exploding_o), 32'h0);
        check_eq("t6_rst_step", 32'(bus.explode_step_o), 32'h0);
        check_eq("t6_rst_score", 32'(bus.score_o), 32'h0);
        check_eq("t6_rst_kill", {21'b0, bus.kill_o, bus.disappear_o}, 32'h0);
        check_eq("t6_rst_flash", 32'(bus.flash_o), 32'h0);
        check_eq("t6_rst_sat_score", 32'(bus_sat.score_o), 32'h0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        check_eq("t6_post_exploding", 32'(bus.exploding_o), 32'h0);
        check_eq("t6_post_score", 32'(bus.score_o), 32'h0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
